fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the decoder. Issues 8-byte-aligned read requests to the memory port and splits each 64-bit response beat into two 32-bit instructions. Buffers the instructions with their PCs in a small queue and presents them one at a time to the decoder's `instruction` input under a valid/ready handshake. Handles PC redirects from the branch/jump logic by flushing buffered and in-flight fetches.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/instr_queue.sv | 69 ++++++
 rtl/fetch_unit.sv | 133 +++++++++++++
 tb/tb_fetch_unit.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

  localparam int FETCH_BEAT_W = 64;
  localparam int INSTR_W      = 32;

endpackage

// File: rtl/instr_queue.sv
// Instruction queue: synchronous FIFO of {pc, instr} entries with up to two
// pushes per cycle, one pop, a flush and a registered head.
module instr_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               push0,
  input  logic [PC_W-1:0]    push0_pc,
  input  logic [INSTR_W-1:0] push0_instr,
  input  logic               push1,
  input  logic [PC_W-1:0]    push1_pc,
  input  logic [INSTR_W-1:0] push1_instr,
  input  logic               pop,
  output logic [CNT_W-1:0]   free_count,
  output logic               head_valid,
  output logic [PC_W-1:0]    head_pc,
  output logic [INSTR_W-1:0] head_instr
);

  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               do_pop;

  assign do_pop     = pop && (count != '0);
  assign free_count = CNT_W'(DEPTH) - count;
  assign head_valid = (count != '0);
  assign head_pc    = pc_mem[rd_ptr];
  assign head_instr = instr_mem[rd_ptr];

  // Storage and pointer update; flush empties the queue but leaves stale data behind the pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push0) begin
        pc_mem[wr_ptr]    <= push0_pc;
        instr_mem[wr_ptr] <= push0_instr;
      end
      if (push1) begin
        pc_mem[wr_ptr + PTR_W'(1)]    <= push1_pc;
        instr_mem[wr_ptr + PTR_W'(1)] <= push1_instr;
      end
      wr_ptr <= wr_ptr + PTR_W'(push0) + PTR_W'(push1);
      rd_ptr <= rd_ptr + PTR_W'(do_pop);
      count  <= count + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues 8-byte reads, splits each beat into two
// instructions and hands them to the decoder through instr_queue.
// Optional build macro: FETCH_TRACE_EN prints delivered and dropped fetches.
//
// state   | meaning
// IDLE    | waiting for at least two free queue slots
// REQ     | read request presented, waiting for acceptance
// WAIT    | request accepted, waiting for the response beat
// DISCARD | a stale response is still in flight and will be dropped
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    redirect_valid,
  input  logic [ADDR_W-1:0]       redirect_pc,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_W-1:0]       mem_req_addr,
  input  logic                    mem_resp_valid,
  input  logic [FETCH_BEAT_W-1:0] mem_resp_data,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic [INSTR_W-1:0]      instruction,
  output logic [ADDR_W-1:0]       instr_pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t       state, state_next;
  logic [ADDR_W-1:0]  fetch_pc, fetch_pc_next;
  logic               flush, push0, push1, pop;
  logic [ADDR_W-1:0]  push0_pc, push1_pc;
  logic [INSTR_W-1:0] push0_instr, push1_instr;
  logic [CNT_W-1:0]   free_count;

  assign mem_req_addr = {fetch_pc[ADDR_W-1:3], 3'b000};
  assign pop          = instr_valid && instr_ready;

  // State and fetch PC registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
    end
  end

  // Next-state, fetch PC advance and queue push control; redirect overrides everything
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    flush         = 1'b0;
    push0         = 1'b0;
    push1         = 1'b0;
    push0_pc      = fetch_pc;
    push0_instr   = mem_resp_data[31:0];
    push1_pc      = {fetch_pc[ADDR_W-1:3], 3'b100};
    push1_instr   = mem_resp_data[63:32];
    mem_req_valid = (state == REQ);
    if (redirect_valid) begin
      flush         = 1'b1;
      fetch_pc_next = redirect_pc & ~ADDR_W'(3);
      case (state)
        IDLE:    state_next = IDLE;
        REQ:     state_next = mem_req_ready ? DISCARD : IDLE;
        WAIT:    state_next = mem_resp_valid ? IDLE : DISCARD;
        DISCARD: state_next = mem_resp_valid ? IDLE : DISCARD;
        default: state_next = IDLE;
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (free_count >= CNT_W'(2)) state_next = REQ;
        end
        REQ: begin
          if (mem_req_ready) state_next = WAIT;
        end
        WAIT: begin
          if (mem_resp_valid) begin
            state_next    = IDLE;
            push0         = 1'b1;
            fetch_pc_next = {fetch_pc[ADDR_W-1:3] + (ADDR_W-3)'(1), 3'b000};
            // An odd-word PC only wants the upper half of the beat
            if (fetch_pc[2]) push0_instr = mem_resp_data[63:32];
            else             push1       = 1'b1;
          end
        end
        DISCARD: begin
          if (mem_resp_valid) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  instr_queue #(
    .DEPTH (DEPTH),
    .PC_W  (ADDR_W)
  ) u_queue (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .push0       (push0),
    .push0_pc    (push0_pc),
    .push0_instr (push0_instr),
    .push1       (push1),
    .push1_pc    (push1_pc),
    .push1_instr (push1_instr),
    .pop         (pop),
    .free_count  (free_count),
    .head_valid  (instr_valid),
    .head_pc     (instr_pc),
    .head_instr  (instruction)
  );

`ifdef FETCH_TRACE_EN
  // Trace of instructions handed to the decoder and of dropped stale beats
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (instr_valid && instr_ready) $display("fetch %h: %h", instr_pc, instruction);
      if (mem_resp_valid && state == DISCARD) $display("fetch discard");
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by
// randomized traffic against a queue-level reference model.
module tb_fetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [63:0] RPC   = 64'h1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [63:0] instr_pc;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_W   (64),
    .DEPTH    (DEPTH),
    .RESET_PC (RPC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instruction    (instruction),
    .instr_pc       (instr_pc)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  // reference model: expected decoder-visible queue, next fetch PC, outstanding request
  ent_t        mq[$];
  logic [63:0] fptr;
  bit          outst, stale;
  // memory model
  bit          pend;
  int          pcnt;
  logic [63:0] paddr;
  int          lat = 1;
  bit          fixed_en = 1'b0;
  logic [63:0] fixed_data = '0;
  // request stability tracking and logs
  bit          prev_hold;
  logic [63:0] prev_addr;
  int          hs_count = 0;
  logic [63:0] hs_log[$];
  int          pops = 0;

  function automatic logic [31:0] word_at(logic [63:0] a);
    return a[31:0] ^ 32'h5A3C_9E11 ^ {a[15:0], a[47:32]};
  endfunction

  function automatic bit resp_due();
    return pend && (pcnt == 0);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    fptr      = RPC;
    outst     = 1'b0;
    stale     = 1'b0;
    pend      = 1'b0;
    pcnt      = 0;
    prev_hold = 1'b0;
  endtask

  task automatic check_reset_values(string tag);
    check({tag, "_req_valid"},   mem_req_valid, 1'b0);
    check({tag, "_instr_valid"}, instr_valid,   1'b0);
    check({tag, "_instruction"}, instruction,   32'h0);
    check({tag, "_instr_pc"},    instr_pc,      64'h0);
    check({tag, "_req_addr"},    mem_req_addr,  64'h1000);
  endtask

  // One clock cycle: drive inputs, compare DUT against the model, advance the model.
  task automatic step_cycle(input bit rq_rdy, input bit in_rdy, input bit redir,
                            input logic [63:0] rpc);
    bit          resp, hs, pop;
    logic [63:0] d;
    resp = resp_due();
    d    = fixed_en ? fixed_data : {word_at(paddr + 64'd4), word_at(paddr)};
    mem_req_ready  = rq_rdy;
    instr_ready    = in_rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    mem_resp_valid = resp;
    mem_resp_data  = resp ? d : {$urandom, $urandom};

    check("instr_valid", instr_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check("instr_pc", instr_pc, mq[0].pc);
      check("instruction", instruction, mq[0].instr);
    end
    if (mem_req_valid) begin
      check("req_addr", mem_req_addr, {fptr[63:3], 3'b000});
      check("req_while_outstanding", outst, 1'b0);
      check("req_with_room", (DEPTH - mq.size()) >= 2, 1'b1);
    end
    if (prev_hold) begin
      check("req_held", mem_req_valid, 1'b1);
      check("req_addr_held", mem_req_addr, prev_addr);
    end

    hs  = mem_req_valid && rq_rdy;
    pop = (mq.size() != 0) && in_rdy;

    if (redir) begin
      mq.delete();
      fptr = rpc & ~64'h3;
      if (resp) begin
        outst = 1'b0;
        stale = 1'b0;
      end else if (outst) begin
        stale = 1'b1;
      end
      if (hs) begin
        outst = 1'b1;
        stale = 1'b1;
      end
    end else begin
      if (pop) begin
        void'(mq.pop_front());
        pops++;
      end
      if (resp) begin
        if (!stale) begin
          if (fptr[2] == 1'b0) begin
            mq.push_back('{pc: fptr, instr: d[31:0]});
            mq.push_back('{pc: fptr + 64'd4, instr: d[63:32]});
          end else begin
            mq.push_back('{pc: fptr, instr: d[63:32]});
          end
          fptr = {fptr[63:3], 3'b000} + 64'd8;
        end
        outst = 1'b0;
        stale = 1'b0;
      end
      if (hs) begin
        outst = 1'b1;
        stale = 1'b0;
      end
    end

    if (resp) pend = 1'b0;
    else if (pend) pcnt--;
    if (hs) begin
      hs_count++;
      hs_log.push_back(mem_req_addr);
      pend  = 1'b1;
      pcnt  = lat - 1;
      paddr = mem_req_addr;
    end

    prev_hold = mem_req_valid && !rq_rdy && !redir;
    prev_addr = mem_req_addr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit found;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    instr_ready    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst");
    reset = 1'b0;

    // Basic fetch with 1-cycle memory latency and a fixed beat
    fixed_en   = 1'b1;
    fixed_data = 64'h00500093_00000013;
    lat        = 1;
    check("first_cycle_idle", mem_req_valid, 1'b0);
    step_cycle(1, 1, 0, '0);
    check("first_req_valid", mem_req_valid, 1'b1);
    check("first_req_addr", mem_req_addr, 64'h1000);
    step_cycle(1, 1, 0, '0);
    step_cycle(1, 1, 0, '0);
    check("lit_valid0", instr_valid, 1'b1);
    check("lit_instr0", instruction, 32'h00000013);
    check("lit_pc0", instr_pc, 64'h1000);
    step_cycle(1, 1, 0, '0);
    check("lit_instr1", instruction, 32'h00500093);
    check("lit_pc1", instr_pc, 64'h1004);
    check("lit_next_req", mem_req_valid, 1'b1);
    check("lit_next_addr", mem_req_addr, 64'h1008);

    // Redirect to an odd word while the request is pending but not accepted
    step_cycle(0, 0, 1, 64'h2004);
    check("withdraw_req", mem_req_valid, 1'b0);
    check("flush_valid", instr_valid, 1'b0);
    fixed_en = 1'b0;
    hs_count = 0;
    hs_log.delete();
    repeat (20) step_cycle(1, 0, 0, '0);
    check("full_hs_count", hs_count, 2);
    check("odd_req_addr", hs_log[0], 64'h2000);
    check("next_req_addr", hs_log[1], 64'h2008);
    check("odd_head_pc", instr_pc, 64'h2004);
    check("odd_head_instr", instruction, word_at(64'h2004));
    check("full_no_req", mem_req_valid, 1'b0);
    step_cycle(1, 1, 0, '0);
    step_cycle(1, 1, 0, '0);
    repeat (10) step_cycle(1, 0, 0, '0);
    check("resume_hs_count", hs_count, 3);
    check("resume_addr", hs_log[2], 64'h2010);

    // Redirect in the same cycle as a response beat
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (resp_due()) found = 1'b1;
      else step_cycle(1, 1, 0, '0);
    end
    check("wait_resp_c", found, 1'b1);
    step_cycle(1, 1, 1, 64'h3000);
    check("c_flush_valid", instr_valid, 1'b0);
    check("c_idle", mem_req_valid, 1'b0);
    step_cycle(1, 1, 0, '0);
    check("c_req_valid", mem_req_valid, 1'b1);
    check("c_req_addr", mem_req_addr, 64'h3000);

    // Redirect during WAIT with a 3-cycle memory
    lat   = 3;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (pend && pcnt == 2) found = 1'b1;
      else step_cycle(1, 1, 0, '0);
    end
    check("wait_wait_d", found, 1'b1);
    step_cycle(1, 1, 1, 64'h4000);
    hs_log.delete();
    for (int i = 0; i < 30 && hs_log.size() == 0; i++) step_cycle(1, 1, 0, '0);
    check("d_req_after_discard", hs_log.size(), 1);
    check("d_req_addr", hs_log[0], 64'h4000);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (instr_valid) found = 1'b1;
      else step_cycle(1, 0, 0, '0);
    end
    check("d_new_beat", found, 1'b1);
    check("d_head_pc", instr_pc, 64'h4000);

    // Reset while a request is pending and not accepted
    lat   = 1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (mem_req_valid) found = 1'b1;
      else step_cycle(0, 1, 0, '0);
    end
    check("wait_req_e", found, 1'b1);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b0;
    @(posedge clk);
    #1;
    check_reset_values("midrst");
    model_reset();
    reset = 1'b0;

    // Randomized traffic
    pops = 0;
    for (int i = 0; i < 3000; i++) begin
      bit          rq, ir, rd;
      logic [63:0] rpc;
      lat = $urandom_range(1, 4);
      rq  = ($urandom_range(0, 9) < 7);
      ir  = ($urandom_range(0, 9) < 6);
      rd  = ($urandom_range(0, 99) < 3);
      rpc = {$urandom, $urandom};
      step_cycle(rq, ir, rd, rpc);
    end
    check("liveness", pops > 300, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
